pip_regs_ctrl: RTL and testbench

Parametrised pipeline-register bank for the rv32i pipeline. It holds STAGES independent inter-stage registers, numbered 0 (fetch/decode) to STAGES-1 (last before writeback). Each register carries a payload and a valid bit. The block resolves per-register hold requests into backward-propagated stalls, inserts bubbles downstream of a stall, applies per-register flushes, and keeps stall and bubble statistics.

---
 rtl/pip_regs_ctrl_if.sv | 28 ++
 rtl/pip_regs_ctrl.sv | 99 +++++++++
 tb/tb_pip_regs_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pip_regs_ctrl_if.sv
// Bundled data/control signals of the pipeline-register bank.
// master drives the next-stage inputs; slave is the register bank itself.
interface pip_regs_ctrl_if #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned WIDTH  = 128,
    parameter int unsigned CNT_W  = 32
);
    logic [STAGES*WIDTH-1:0] i_data;
    logic [STAGES-1:0]       i_valid;
    logic [STAGES-1:0]       i_hold_req;
    logic [STAGES-1:0]       i_flush;
    logic                    i_cnt_clr;
    logic [STAGES*WIDTH-1:0] o_data;
    logic [STAGES-1:0]       o_valid;
    logic [STAGES-1:0]       o_hold;
    logic [CNT_W-1:0]        o_stall_cnt;
    logic [CNT_W-1:0]        o_bubble_cnt;

    modport master (
        output i_data, i_valid, i_hold_req, i_flush, i_cnt_clr,
        input  o_data, o_valid, o_hold, o_stall_cnt, o_bubble_cnt
    );

    modport slave (
        input  i_data, i_valid, i_hold_req, i_flush, i_cnt_clr,
        output o_data, o_valid, o_hold, o_stall_cnt, o_bubble_cnt
    );
endinterface

// File: rtl/pip_regs_ctrl.sv
// Pipeline-register bank: backward stall propagation, bubble insertion below
// a stall, per-register flush, and saturating stall/bubble statistics.
module pip_regs_ctrl #(
    parameter int unsigned STAGES      = 4,
    parameter int unsigned WIDTH       = 128,
    parameter bit          BUBBLE_ZERO = 1'b1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic           clk,
    input  logic           rst,
    pip_regs_ctrl_if.slave bus
);

    logic [STAGES*WIDTH-1:0] data_q, data_d;
    logic [STAGES-1:0]       valid_q, valid_d;
    logic [CNT_W-1:0]        stall_q, stall_d;
    logic [CNT_W-1:0]        bubble_q, bubble_d;

    logic [STAGES-1:0]       hold;
    logic [STAGES-1:0]       hold_up;
    logic [CNT_W:0]          n_bub;
    logic [CNT_W:0]          bub_sum;
    logic [WIDTH-1:0]        slice;
    logic [WIDTH-1:0]        fill;

    // Register k stalls if it or any register downstream of it is held;
    // computed as a reduction rather than a ripple chain.
    always_comb begin
        hold = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            hold[k] = |(bus.i_hold_req >> k);
        end
    end

    assign hold_up = {hold[STAGES-2:0], 1'b0};

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        n_bub   = '0;
        slice   = '0;
        fill    = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice = bus.i_data[k*WIDTH +: WIDTH];
            fill  = BUBBLE_ZERO ? '0 : slice;
            if (bus.i_flush[k]) begin
                data_d[k*WIDTH +: WIDTH] = fill;
                valid_d[k]               = 1'b0;
            end else if (hold[k]) begin
                data_d[k*WIDTH +: WIDTH] = data_q[k*WIDTH +: WIDTH];
                valid_d[k]               = valid_q[k];
            end else if (hold_up[k]) begin
                data_d[k*WIDTH +: WIDTH] = fill;
                valid_d[k]               = 1'b0;
                n_bub                    = n_bub + (CNT_W+1)'(1);
            end else begin
                data_d[k*WIDTH +: WIDTH] = slice;
                valid_d[k]               = bus.i_valid[k];
            end
        end
    end

    // Bubble count may add several per edge, so saturate on the carry-out.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        bub_sum  = {1'b0, bubble_q} + n_bub;
        if (bus.i_cnt_clr) begin
            stall_d  = '0;
            bubble_d = '0;
        end else begin
            if (hold[0] && (stall_q != '1)) begin
                stall_d = stall_q + CNT_W'(1);
            end
            bubble_d = bub_sum[CNT_W] ? '1 : bub_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            valid_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign bus.o_data       = data_q;
    assign bus.o_valid      = valid_q;
    assign bus.o_hold       = hold;
    assign bus.o_stall_cnt  = stall_q;
    assign bus.o_bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pip_regs_ctrl.sv
// Bench for pip_regs_ctrl: two configurations (zero-fill/32-bit counters and
// data-fill/4-bit counters) share one stimulus and one reference model.
module tb_pip_regs_ctrl;

    localparam int unsigned S = 4;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [S*W-1:0] i_data;
    logic [S-1:0]   i_valid, i_hold_req, i_flush;
    logic           i_cnt_clr;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pip_regs_ctrl_if #(.STAGES(S), .WIDTH(W), .CNT_W(32)) ifa ();
    pip_regs_ctrl_if #(.STAGES(S), .WIDTH(W), .CNT_W(4))  ifb ();

    assign ifa.i_data = i_data;     assign ifb.i_data = i_data;
    assign ifa.i_valid = i_valid;   assign ifb.i_valid = i_valid;
    assign ifa.i_hold_req = i_hold_req; assign ifb.i_hold_req = i_hold_req;
    assign ifa.i_flush = i_flush;   assign ifb.i_flush = i_flush;
    assign ifa.i_cnt_clr = i_cnt_clr; assign ifb.i_cnt_clr = i_cnt_clr;

    pip_regs_ctrl #(.STAGES(S), .WIDTH(W), .BUBBLE_ZERO(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    pip_regs_ctrl #(.STAGES(S), .WIDTH(W), .BUBBLE_ZERO(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    // Reference state: index 0 = zero-fill config, index 1 = data-fill config.
    logic [W-1:0]     m_data [2][S];
    logic             m_valid[2][S];
    longint unsigned  m_stall[2];
    longint unsigned  m_bub[2];
    longint unsigned  m_max[2] = '{64'hFFFF_FFFF, 64'd15};

    function automatic logic [S-1:0] ref_hold(input logic [S-1:0] req);
        logic [S-1:0] h = '0;
        for (int k = 0; k < S; k++)
            for (int j = k; j < S; j++)
                if (req[j]) h[k] = 1'b1;
        return h;
    endfunction

    function automatic longint unsigned sat_add(input longint unsigned a, input longint unsigned b,
                                                input longint unsigned mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic model_update();
        logic [S-1:0] h = ref_hold(i_hold_req);
        for (int d = 0; d < 2; d++) begin
            int nb = 0;
            if (rst) begin
                for (int k = 0; k < S; k++) begin m_data[d][k] = '0; m_valid[d][k] = 1'b0; end
                m_stall[d] = 0;
                m_bub[d]   = 0;
            end else begin
                for (int k = 0; k < S; k++) begin
                    logic [W-1:0] sl = i_data[k*W +: W];
                    if (i_flush[k]) begin
                        m_data[d][k] = (d == 0) ? '0 : sl; m_valid[d][k] = 1'b0;
                    end else if (h[k]) begin
                        // held: unchanged
                    end else if (k > 0 && h[k-1]) begin
                        m_data[d][k] = (d == 0) ? '0 : sl; m_valid[d][k] = 1'b0; nb++;
                    end else begin
                        m_data[d][k] = sl; m_valid[d][k] = i_valid[k];
                    end
                end
                if (i_cnt_clr) begin
                    m_stall[d] = 0;
                    m_bub[d]   = 0;
                end else begin
                    m_stall[d] = sat_add(m_stall[d], h[0] ? 1 : 0, m_max[d]);
                    m_bub[d]   = sat_add(m_bub[d], longint'(nb), m_max[d]);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [S*W-1:0] pack_model(input int d);
        logic [S*W-1:0] v;
        for (int k = 0; k < S; k++) v[k*W +: W] = m_data[d][k];
        return v;
    endfunction

    function automatic logic [S-1:0] pack_valid(input int d);
        logic [S-1:0] v;
        for (int k = 0; k < S; k++) v[k] = m_valid[d][k];
        return v;
    endfunction

    // One clock: combinational hold check, edge, then registered checks.
    task automatic step();
        #1;
        chk("hold_a", 128'(ifa.o_hold), 128'(ref_hold(i_hold_req)));
        chk("hold_b", 128'(ifb.o_hold), 128'(ref_hold(i_hold_req)));
        @(posedge clk);
        model_update();
        #1;
        chk("data_a",  128'(ifa.o_data),       128'(pack_model(0)));
        chk("valid_a", 128'(ifa.o_valid),      128'(pack_valid(0)));
        chk("stall_a", 128'(ifa.o_stall_cnt),  128'(m_stall[0]));
        chk("bub_a",   128'(ifa.o_bubble_cnt), 128'(m_bub[0]));
        chk("data_b",  128'(ifb.o_data),       128'(pack_model(1)));
        chk("valid_b", 128'(ifb.o_valid),      128'(pack_valid(1)));
        chk("stall_b", 128'(ifb.o_stall_cnt),  128'(m_stall[1]));
        chk("bub_b",   128'(ifb.o_bubble_cnt), 128'(m_bub[1]));
    endtask

    typedef struct {
        logic [S-1:0]   hold, flush, valid;
        logic           clr;
        logic [S*W-1:0] data;
        logic [S-1:0]   e_hold, e_valid;
        logic [S*W-1:0] e_data_a, e_data_b;
        int unsigned    e_stall, e_bub;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{4'h0, 4'h0, 4'hF, 1'b0, 128'h00000044_00000033_00000022_00000011,
                   4'h0, 4'hF, 128'h00000044_00000033_00000022_00000011,
                   128'h00000044_00000033_00000022_00000011, 0, 0};
        tbl[1] = '{4'h4, 4'h0, 4'hF, 1'b0, 128'h000000A3_000000A2_000000A1_000000A0,
                   4'h7, 4'h7, 128'h00000000_00000033_00000022_00000011,
                   128'h000000A3_00000033_00000022_00000011, 1, 1};
        tbl[2] = tbl[1]; tbl[2].e_stall = 2; tbl[2].e_bub = 2;
        tbl[3] = tbl[1]; tbl[3].e_stall = 3; tbl[3].e_bub = 3;
        tbl[4] = '{4'h2, 4'h2, 4'hF, 1'b0, 128'h000000B3_000000B2_000000B1_000000B0,
                   4'h3, 4'h9, 128'h000000B3_00000000_00000000_00000011,
                   128'h000000B3_000000B2_000000B1_00000011, 4, 4};
        tbl[5] = '{4'h0, 4'hF, 4'hF, 1'b0, 128'h000000C3_000000C2_000000C1_000000C0,
                   4'h0, 4'h0, 128'h0,
                   128'h000000C3_000000C2_000000C1_000000C0, 4, 4};
        tbl[6] = '{4'h0, 4'h0, 4'h5, 1'b0, 128'h000000D3_000000D2_000000D1_000000D0,
                   4'h0, 4'h5, 128'h000000D3_000000D2_000000D1_000000D0,
                   128'h000000D3_000000D2_000000D1_000000D0, 4, 4};
        tbl[7] = '{4'h1, 4'h0, 4'hF, 1'b0, 128'h000000E3_000000E2_000000E1_000000E0,
                   4'h1, 4'hD, 128'h000000E3_000000E2_00000000_000000D0,
                   128'h000000E3_000000E2_000000E1_000000D0, 5, 5};
        tbl[8] = '{4'h1, 4'h0, 4'hF, 1'b1, 128'h000000F3_000000F2_000000F1_000000F0,
                   4'h1, 4'hD, 128'h000000F3_000000F2_00000000_000000D0,
                   128'h000000F3_000000F2_000000F1_000000D0, 0, 0};
        tbl[9] = '{4'h0, 4'h0, 4'h0, 1'b0, 128'h00000004_00000003_00000002_00000001,
                   4'h0, 4'h0, 128'h00000004_00000003_00000002_00000001,
                   128'h00000004_00000003_00000002_00000001, 0, 0};

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < S; k++) begin m_data[d][k] = '0; m_valid[d][k] = 1'b0; end
            m_stall[d] = 0; m_bub[d] = 0;
        end
        rst = 1'b1; i_data = '0; i_valid = '0; i_hold_req = '0; i_flush = '0; i_cnt_clr = 1'b0;

        step(); step();
        chk("rst_data",  128'(ifa.o_data), 128'h0);
        chk("rst_valid", 128'(ifa.o_valid), 128'h0);
        chk("rst_stall", 128'(ifa.o_stall_cnt), 128'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            i_hold_req = tbl[i].hold; i_flush = tbl[i].flush; i_valid = tbl[i].valid;
            i_cnt_clr = tbl[i].clr; i_data = tbl[i].data;
            #1;
            chk("tbl_hold", 128'(ifa.o_hold), 128'(tbl[i].e_hold));
            step();
            chk("tbl_valid_a", 128'(ifa.o_valid), 128'(tbl[i].e_valid));
            chk("tbl_valid_b", 128'(ifb.o_valid), 128'(tbl[i].e_valid));
            chk("tbl_data_a",  128'(ifa.o_data), 128'(tbl[i].e_data_a));
            chk("tbl_data_b",  128'(ifb.o_data), 128'(tbl[i].e_data_b));
            chk("tbl_stall",   128'(ifa.o_stall_cnt), 128'(tbl[i].e_stall));
            chk("tbl_bub",     128'(ifa.o_bubble_cnt), 128'(tbl[i].e_bub));
            chk("tbl_stall_b", 128'(ifb.o_stall_cnt), 128'(tbl[i].e_stall));
        end

        // Mid-stall reset clears everything on the next edge.
        i_hold_req = 4'h2; i_valid = 4'hF; i_data = '1;
        step(); step();
        rst = 1'b1;
        step();
        chk("midrst_data",  128'(ifa.o_data), 128'h0);
        chk("midrst_valid", 128'(ifb.o_valid), 128'h0);
        chk("midrst_stall", 128'(ifa.o_stall_cnt), 128'h0);
        chk("midrst_bub",   128'(ifa.o_bubble_cnt), 128'h0);
        rst = 1'b0; i_hold_req = '0;

        // Stall-counter saturation on the 4-bit config, then clear mid-hold.
        i_hold_req = 4'h1;
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall_b", 128'(ifb.o_stall_cnt), 128'd15);
        chk("sat_stall_a", 128'(ifa.o_stall_cnt), 128'd20);
        chk("sat_bub_b",   128'(ifb.o_bubble_cnt), 128'd15);
        i_cnt_clr = 1'b1;
        step();
        chk("clr_stall_b", 128'(ifb.o_stall_cnt), 128'd0);
        chk("clr_bub_a",   128'(ifa.o_bubble_cnt), 128'd0);
        i_cnt_clr = 1'b0;
        step();
        chk("resume1", 128'(ifb.o_stall_cnt), 128'd1);
        step();
        chk("resume2", 128'(ifb.o_stall_cnt), 128'd2);
        i_hold_req = '0;

        for (int n = 0; n < 10000; n++) begin
            rst = ($urandom_range(0, 499) == 0);
            i_cnt_clr = ($urandom_range(0, 49) == 0);
            i_valid = 4'($urandom);
            for (int k = 0; k < S; k++) begin
                i_hold_req[k] = ($urandom_range(0, 5) == 0);
                i_flush[k]    = ($urandom_range(0, 7) == 0);
                i_data[k*W +: W] = $urandom;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
